// File: rtl/mdc_mac_engine_n.sv
// Joins N_IN input streams and computes signed MUL / MAC / MADD results that are buffered in an output FIFO.
// Build option: define MDC_MAC_ENGINE_SATURATE_EN to saturate MAC and MADD sums (the default build wraps them).
module mdc_mac_engine_n #(
  parameter int DW         = 32,
  parameter int N_IN       = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      start_i,
  input  logic [CNT_W-1:0]          len_i,
  input  logic [1:0]                mode_i,
  input  logic [N_IN-1:0][DW-1:0]   in_data_i,
  input  logic [N_IN-1:0]           in_valid_i,
  output logic [N_IN-1:0]           in_ready_o,
  output logic [DW-1:0]             out_data_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [CNT_W-1:0]          cnt_o,
  output logic [1:0]                state_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     len_q, cnt_q;
  logic [1:0]           mode_q;
  logic [DW-1:0]        acc_q, res_q;
  logic                 res_vld_q;
  logic [DW-1:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          fcnt_q;

  logic [AW+1:0]        occ;
  logic                 space, fire, last_beat, emit, push, pop;
  logic [DW-1:0]        prod, mac_val, madd_val, res_val;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high.
  // Inputs are joined, so every in_ready_o bit is the same fire term; the output
  // holds out_data_o stable while out_valid_o is high and out_ready_i is low.
  assign occ        = {1'b0, fcnt_q} + {{(AW+1){1'b0}}, res_vld_q};
  assign space      = occ < (AW+2)'(FIFO_DEPTH);
  assign fire       = (state_q == S_RUN) && (&in_valid_i) && space && !clear_i;
  assign last_beat  = fire && (cnt_q == len_q - CNT_W'(1));
  assign emit       = fire && ((mode_q != 2'd1) || last_beat);
  assign push       = res_vld_q;
  assign pop        = out_valid_o && out_ready_i;

  assign in_ready_o  = {N_IN{fire}};
  assign out_valid_o = (fcnt_q != '0);
  assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign cnt_o       = cnt_q;
  assign state_o     = state_q;

  // Low DW bits of the product are the same for signed and unsigned operands.
  assign prod = in_data_i[0] * in_data_i[1];

`ifdef MDC_MAC_ENGINE_SATURATE_EN
  localparam int SW = DW + 4;
  logic [SW-1:0] madd_w;

  function automatic logic [SW-1:0] sext(input logic [DW-1:0] v);
    return {{(SW-DW){v[DW-1]}}, v};
  endfunction

  function automatic logic [DW-1:0] sat(input logic [SW-1:0] v);
    if ($signed(v) > $signed({{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}}))
      return {1'b0, {(DW-1){1'b1}}};
    else if ($signed(v) < $signed({{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}}))
      return {1'b1, {(DW-1){1'b0}}};
    return v[DW-1:0];
  endfunction

  always_comb begin
    madd_w = sext(prod);
    for (int k = 2; k < N_IN; k++) madd_w = madd_w + sext(in_data_i[k]);
  end

  assign madd_val = sat(madd_w);
  assign mac_val  = sat(sext(acc_q) + sext(prod));
`else
  always_comb begin
    madd_val = prod;
    for (int k = 2; k < N_IN; k++) madd_val = madd_val + in_data_i[k];
  end

  assign mac_val = acc_q + prod;
`endif

  always_comb begin
    res_val = prod;
    if (mode_q == 2'd1)      res_val = mac_val;
    else if (mode_q == 2'd2) res_val = madd_val;
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = (len_i != '0) ? S_RUN : S_DONE;
      S_RUN: begin
        busy_o = 1'b1;
        if (last_beat) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy_o = 1'b1;
        if (!res_vld_q && (fcnt_q == '0)) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = !clear_i;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      mode_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fcnt_q    <= '0;
    end else if (clear_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      res_vld_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fcnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && start_i) begin
        len_q  <= len_i;
        mode_q <= mode_i;
        cnt_q  <= '0;
        acc_q  <= '0;
      end
      if (fire) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (mode_q == 2'd1) acc_q <= mac_val;
      end
      res_vld_q <= emit;
      if (emit) res_q <= res_val;
      // The fire gate keeps occupancy plus stage within depth, so a push always has room.
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      fcnt_q <= fcnt_q + (AW+1)'(1);
      else if (!push && pop) fcnt_q <= fcnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= res_q;
  end

endmodule
